// File: rtl/asconp_round_ctrl.sv
// Ascon permutation round sequencer for the LUT-based round datapath.
// Also arbitrates S-box LUT config access against in-flight permutations.
module asconp_round_ctrl #(
  parameter int UROL       = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [3:0]   rounds_i,
  input  logic [319:0] state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] state_o,
  output logic         err_o,
  output logic [3:0]   perm_round_cnt_o,
  output logic [319:0] perm_x_o,
  input  logic [319:0] perm_x_i,
  input  logic         cfg_req_i,
  output logic         cfg_gnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  fsm_e         st_q, st_d;
  logic [319:0] x_q, x_d;
  logic [3:0]   rc_q, rc_d;
  logic         err_q, err_d;
  logic         gnt_q, gnt_d;
  logic         accept;
  logic         legal;
  logic         last;
  logic [4:0]   rc_sum;

  assign in_ready_o = (st_q == IDLE)
                    && !cfg_req_i
                    && !gnt_q;
  assign accept = in_valid_i && in_ready_o;

  assign legal = (rounds_i != 4'd0)
              && (int'(rounds_i) <= MAX_ROUNDS)
              && ((int'(rounds_i) % UROL) == 0);

  // 5-bit sum so the final step to MAX_ROUNDS never wraps
  assign rc_sum = {1'b0, rc_q} + 5'(UROL);
  assign last   = (rc_sum == 5'(MAX_ROUNDS));

  assign out_valid_o      = (st_q == DONE);
  assign state_o          = x_q;
  assign perm_x_o         = x_q;
  assign perm_round_cnt_o = rc_q;
  assign err_o            = err_q;
  assign cfg_gnt_o        = gnt_q;

  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    rc_d  = rc_q;
    err_d = 1'b0;
    gnt_d = cfg_req_i
         && (gnt_q || (st_q == IDLE));
    unique case (st_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            st_d = RUN;
            x_d  = state_i;
            rc_d = 4'(MAX_ROUNDS - int'(rounds_i));
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        x_d = perm_x_i;
        if (last) begin
          st_d = DONE;
          rc_d = '0;
        end else begin
          rc_d = rc_sum[3:0];
        end
      end
      DONE: begin
        if (out_ready_i) begin
          st_d = IDLE;
          rc_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q  <= IDLE;
      x_q   <= '0;
      rc_q  <= '0;
      err_q <= 1'b0;
      gnt_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      rc_q  <= rc_d;
      err_q <= err_d;
      gnt_q <= gnt_d;
    end
  end

endmodule
